// File: rtl/led_pwm_pkg.sv
//------------------------------------------------------------------------------
// led_pwm_pkg : shared widths, defaults and fade FSM encoding for the LED PWM chain
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package led_pwm_pkg;

  localparam int unsigned LED_W      = 8;
  localparam int unsigned LED_RATE_W = 4;
  localparam int unsigned LED_STEP   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } fade_state_t;

endpackage

`default_nettype wire

// File: rtl/period_prescaler.sv
//------------------------------------------------------------------------------
// period_prescaler : counts PWM period ticks, fires once every (rate+1) ticks
// Revision         : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module period_prescaler #(
  parameter int unsigned RATE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              clr,
  input  logic              tick,
  input  logic [RATE_W-1:0] rate,
  output logic              fire
);

  logic [RATE_W-1:0] count_q;
  logic [RATE_W-1:0] count_d;

  // >= so that lowering rate below the running count fires on the next tick
  assign fire = en && tick && !clr && (count_q >= rate);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = fire ? '0 : count_q + RATE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_fade_ramp.sv
//------------------------------------------------------------------------------
// led_fade_ramp : steps a linear brightness level toward target on PWM period ends
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module led_fade_ramp
  import led_pwm_pkg::*;
#(
  parameter int unsigned W      = LED_W,
  parameter int unsigned RATE_W = LED_RATE_W,
  parameter int unsigned STEP   = LED_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [W-1:0]      target,
  input  logic [RATE_W-1:0] rate,
  input  logic              load,
  input  logic              period_end,
  output logic [W-1:0]      level,
  output logic              level_valid,
  output logic              busy,
  output logic              at_target
);

  localparam logic [W:0]   STEP_EXT = (W+1)'(STEP);
  localparam logic [W-1:0] STEP_W   = W'(STEP);

  fade_state_t  state_q, state_d;
  logic [W-1:0] level_q, level_d;
  logic         valid_q, valid_d;

  logic         tgt_gt, tgt_lt, ramping, fire;
  logic [W:0]   diff_up, diff_dn;
  logic [W-1:0] up_val, dn_val;

  assign tgt_gt = target > level_q;
  assign tgt_lt = target < level_q;

  // Only a ramp still heading toward target advances the prescaler;
  // the direction-swap cycle and the settle cycle leave it untouched.
  assign ramping = ((state_q == UP) && tgt_gt) || ((state_q == DOWN) && tgt_lt);

  assign diff_up = {1'b0, target} - {1'b0, level_q};
  assign diff_dn = {1'b0, level_q} - {1'b0, target};
  assign up_val  = (diff_up < STEP_EXT) ? target : level_q + STEP_W;
  assign dn_val  = (diff_dn < STEP_EXT) ? target : level_q - STEP_W;

  period_prescaler #(
    .RATE_W (RATE_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena),
    .clr   (load || (state_q == IDLE)),
    .tick  (period_end && ramping),
    .rate  (rate),
    .fire  (fire)
  );

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (load) begin
      level_d = target;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (tgt_gt)      state_d = UP;
          else if (tgt_lt) state_d = DOWN;
        end
        UP: begin
          if (tgt_lt)       state_d = DOWN;
          else if (!tgt_gt) state_d = IDLE;
          else if (fire)    level_d = up_val;
        end
        DOWN: begin
          if (tgt_gt)       state_d = UP;
          else if (!tgt_lt) state_d = IDLE;
          else if (fire)    level_d = dn_val;
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d = (level_d != level_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      level_q <= '0;
      valid_q <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign level       = level_q;
  assign level_valid = valid_q && ena;
  assign busy        = (state_q != IDLE);
  assign at_target   = (level_q == target);

endmodule

`default_nettype wire
